// File: rtl/simon_btn_input.sv
// -----------------------------------------------------------------------------
// simon_btn_input
//
// Converts the four raw Simon push-buttons into debounced, decoded colour
// events for the game controller. Each button is synchronised (2 flops),
// debounced, and then tracked by a small FSM that reports single-button
// presses through a valid/ready handshake, echoes the currently held colour,
// and flags multi-button presses and dropped (overrun) presses.
//
// Colour encoding: TL=00, TR=01, BL=10, BR=11.
//
// Optional feature: define SIMON_BTN_TIMEOUT_EN to build the inactivity
// timer that drives 'timeout'; otherwise 'timeout' is tied to 0.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   btn_tl/tr/bl/br in raw asynchronous active-high buttons
//   enable       in   game is accepting player input (gates reporting only)
//   press_valid  out  a decoded press is pending
//   press_color  out  colour of the pending press (stable while valid)
//   press_ready  in   consumer accepts the pending press
//   held_valid   out  exactly one debounced button is down (clean press)
//   held_color   out  colour of the held button, 00 when held_valid=0
//   multi_press  out  1-cycle pulse: a second button went down
//   overrun      out  1-cycle pulse: a press was dropped (one still pending)
//   timeout      out  1-cycle pulse on inactivity (optional feature)
// -----------------------------------------------------------------------------
module simon_btn_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_tl,
  input  logic       btn_tr,
  input  logic       btn_bl,
  input  logic       btn_br,
  input  logic       enable,
  output logic       press_valid,
  output logic [1:0] press_color,
  input  logic       press_ready,
  output logic       held_valid,
  output logic [1:0] held_color,
  output logic       multi_press,
  output logic       overrun,
  output logic       timeout
);

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } state_t;

  // Bit index equals colour code, so decoding a one-hot vector gives colour.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_br, btn_bl, btn_tr, btn_tl};

  logic [3:0]  sync1, sync2;
  logic [3:0]  deb;       // debounced levels
  logic [3:0]  deb_d;     // debounced levels one cycle earlier, for edge detect
  logic [23:0] db_cnt [4];

  // ---------------------------------------------------------------------------
  // Synchroniser and per-button debounce
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      // NOTE: the counter array is only four registers, so it is reset
      // explicitly; a real RAM would not get a reset loop like this.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the
      // pre-edge value, which is what gives the 2-flop synchroniser its delay.
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rise detection, counts and colour of a single rise
  // ---------------------------------------------------------------------------
  logic [3:0] rise;
  logic [2:0] rise_cnt;
  logic [2:0] down_cnt;
  logic [1:0] rise_color;

  assign rise = deb & ~deb_d;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rise_cnt   = '0;
    down_cnt   = '0;
    rise_color = '0;
    for (int i = 0; i < 4; i++) begin
      rise_cnt = rise_cnt + {2'b00, rise[i]};
      down_cnt = down_cnt + {2'b00, deb[i]};
      if (rise[i]) rise_color = 2'(i);
    end
  end

  // A clean single press: one button just went down and nothing else is down.
  logic single_rise;
  logic report;
  logic fire;

  assign single_rise = (rise_cnt == 3'd1) && (down_cnt == 3'd1);

  state_t state;

  assign report = (state == IDLE) && single_rise && enable;
  assign fire   = press_valid & press_ready;

  // ---------------------------------------------------------------------------
  // Press FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      press_valid <= 1'b0;
      press_color <= 2'b00;
      held_valid  <= 1'b0;
      held_color  <= 2'b00;
      multi_press <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      multi_press <= 1'b0;
      overrun     <= 1'b0;

      // A new load in the same cycle as a handshake replaces the old press.
      if (report) begin
        if (!press_valid || fire) begin
          press_valid <= 1'b1;
          press_color <= rise_color;
        end else begin
          overrun <= 1'b1;
        end
      end else if (fire) begin
        press_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rise_cnt != 3'd0) begin
            if (single_rise) begin
              state      <= SINGLE;
              held_valid <= 1'b1;
              held_color <= rise_color;
            end else begin
              state       <= MULTI;
              multi_press <= 1'b1;
            end
          end
        end
        SINGLE: begin
          if (rise_cnt != 3'd0) begin
            state       <= MULTI;
            multi_press <= 1'b1;
            held_valid  <= 1'b0;
            held_color  <= 2'b00;
          end else if (down_cnt == 3'd0) begin
            state      <= IDLE;
            held_valid <= 1'b0;
            held_color <= 2'b00;
          end
        end
        MULTI: begin
          if (down_cnt == 3'd0) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          held_valid <= 1'b0;
          held_color <= 2'b00;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional inactivity timer
  // ---------------------------------------------------------------------------
`ifdef SIMON_BTN_TIMEOUT_EN
  localparam logic [27:0] TO_LAST = 28'(TIMEOUT_CYCLES - 1);

  logic [27:0] idle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!enable || (rise != 4'b0000)) begin
        idle_cnt <= '0;
      end else if ((state == IDLE) && !press_valid) begin
        if (idle_cnt == TO_LAST) begin
          timeout  <= 1'b1;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 28'd1;
        end
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_simon_btn_input.sv
// -----------------------------------------------------------------------------
// tb_simon_btn_input
//
// Directed stimulus with literal expectations at the interesting cycles, plus
// a behavioural model compared against every output on every falling edge.
// The model treats debouncing as "the last DEBOUNCE_CYCLES synchronised
// samples all disagree with the debounced level" over a sample history, and
// treats button activity as gestures: a gesture starts at the first
// debounced press from all-released and ends when everything is released;
// a gesture involving exactly one button is a clean press.
// -----------------------------------------------------------------------------
module tb_simon_btn_input;

  localparam int D = 4;
  localparam int T = 20;
`ifdef SIMON_BTN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk         = 1'b0;
  logic reset       = 1'b1;
  logic btn_tl      = 1'b0;
  logic btn_tr      = 1'b0;
  logic btn_bl      = 1'b0;
  logic btn_br      = 1'b0;
  logic enable      = 1'b0;
  logic press_ready = 1'b0;

  logic       press_valid;
  logic [1:0] press_color;
  logic       held_valid;
  logic [1:0] held_color;
  logic       multi_press;
  logic       overrun;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  simon_btn_input #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_tl     (btn_tl),
    .btn_tr     (btn_tr),
    .btn_bl     (btn_bl),
    .btn_br     (btn_br),
    .enable     (enable),
    .press_valid(press_valid),
    .press_color(press_color),
    .press_ready(press_ready),
    .held_valid (held_valid),
    .held_color (held_color),
    .multi_press(multi_press),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [3:0] samp_q[$];     // raw button samples, one per rising edge
  logic [3:0] m_deb;
  logic [3:0] m_deb_prev;
  logic [3:0] g_buttons;     // every button that went down in this gesture
  bit         g_active;
  logic       m_pv, m_hv, m_multi, m_over, m_to;
  logic [1:0] m_pc, m_hc;
  int         m_idle_run;

  function automatic logic [1:0] colour_of(input logic [3:0] v);
    colour_of = 2'd0;
    for (int b = 0; b < 4; b++) if (v[b]) colour_of = 2'(b);
  endfunction

  task automatic model_reset();
    samp_q.delete();
    for (int k = 0; k < D + 2; k++) samp_q.push_back(4'b0000);
    m_deb      = '0;
    m_deb_prev = '0;
    g_buttons  = '0;
    g_active   = 1'b0;
    m_pv       = 1'b0;
    m_pc       = 2'd0;
    m_hv       = 1'b0;
    m_hc       = 2'd0;
    m_multi    = 1'b0;
    m_over     = 1'b0;
    m_to       = 1'b0;
    m_idle_run = 0;
  endtask

  task automatic model_step();
    logic [3:0] rises, raw, next_deb, s;
    bit was_idle, was_pv, report, fire, stable;
    int n_before;

    raw      = {btn_br, btn_bl, btn_tr, btn_tl};
    rises    = m_deb & ~m_deb_prev;
    was_idle = !g_active;
    was_pv   = m_pv;
    report   = 1'b0;
    m_multi  = 1'b0;
    m_over   = 1'b0;
    m_to     = 1'b0;

    // Gesture tracking
    n_before = $countones(g_buttons);
    if (!g_active) begin
      if (rises != 4'b0000) begin
        g_active  = 1'b1;
        g_buttons = rises;
        if ($countones(rises) == 1) report = 1'b1;
        else m_multi = 1'b1;
      end
    end else begin
      g_buttons = g_buttons | rises;
      if (n_before == 1 && $countones(g_buttons) > 1) m_multi = 1'b1;
      if (m_deb == 4'b0000) begin
        g_active  = 1'b0;
        g_buttons = '0;
      end
    end
    m_hv = g_active && ($countones(g_buttons) == 1);
    m_hc = m_hv ? colour_of(g_buttons) : 2'd0;

    // Pending-press slot
    fire = m_pv && press_ready;
    if (report && enable) begin
      if (!m_pv || fire) begin
        m_pv = 1'b1;
        m_pc = colour_of(rises);
      end else begin
        m_over = 1'b1;
      end
    end else if (fire) begin
      m_pv = 1'b0;
    end

    // Inactivity: the T-th consecutive qualifying cycle pulses
    if (TO_EN) begin
      if (!enable || rises != 4'b0000) begin
        m_idle_run = 0;
      end else if (was_idle && !was_pv) begin
        m_idle_run++;
        if (m_idle_run == T) begin
          m_to       = 1'b1;
          m_idle_run = 0;
        end
      end
    end

    // Debounce: samples from 2..D+1 edges ago must all disagree to flip
    next_deb = m_deb;
    for (int b = 0; b < 4; b++) begin
      stable = 1'b1;
      for (int k = 2; k <= D + 1; k++) begin
        s = samp_q[samp_q.size() - k];
        if (s[b] == m_deb[b]) stable = 1'b0;
      end
      if (stable) next_deb[b] = ~m_deb[b];
    end
    m_deb_prev = m_deb;
    m_deb      = next_deb;
    samp_q.push_back(raw);
    if (samp_q.size() > D + 3) void'(samp_q.pop_front());
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // One compare process: every output against the model, away from the edge
  always @(negedge clk) begin
    if (!reset) begin
      check("model_press_valid", press_valid, m_pv);
      if (m_pv) check("model_press_color", press_color, m_pc);
      check("model_held_valid", held_valid, m_hv);
      check("model_held_color", held_color, m_hc);
      check("model_multi_press", multi_press, m_multi);
      check("model_overrun", overrun, m_over);
      check("model_timeout", timeout, m_to);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    cyc(3);
    check("rst_press_valid", press_valid, 0);
    check("rst_press_color", press_color, 0);
    check("rst_held_valid", held_valid, 0);
    check("rst_held_color", held_color, 0);
    check("rst_multi_press", multi_press, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    reset  = 1'b0;
    enable = 1'b1;
    cyc(2);

    // Single BL press, latency, release, then handshake
    btn_bl = 1'b1;
    cyc(6); check("bl_before_latency", press_valid, 0);
    cyc(1); check("bl_press_valid", press_valid, 1);
    check("bl_press_color", press_color, 2'b10);
    check("bl_held_valid", held_valid, 1);
    check("bl_held_color", held_color, 2'b10);
    btn_bl = 1'b0;
    cyc(6); check("bl_still_held", held_valid, 1);
    cyc(1); check("bl_released", held_valid, 0);
    check("bl_pending_after_release", press_valid, 1);
    cyc(3); check("bl_pending_no_ready", press_valid, 1);
    press_ready = 1'b1; cyc(1); press_ready = 1'b0;
    check("bl_acked", press_valid, 0);
    cyc(2);

    // TR bouncing every 2 cycles, then steady
    for (int i = 0; i < 10; i++) begin
      btn_tr = (i % 2 == 0);
      cyc(2);
    end
    check("bounce_no_press", press_valid, 0);
    btn_tr = 1'b1;
    cyc(6); check("tr_before_latency", press_valid, 0);
    cyc(1); check("tr_press_valid", press_valid, 1);
    check("tr_press_color", press_color, 2'b01);
    btn_tr = 1'b0;
    press_ready = 1'b1; cyc(1); press_ready = 1'b0;
    cyc(10);

    // TL and BR together: multi, no report; then TL alone
    btn_tl = 1'b1;
    btn_br = 1'b1;
    cyc(6); check("multi_not_yet", multi_press, 0);
    cyc(1); check("multi_pulse", multi_press, 1);
    check("multi_no_press", press_valid, 0);
    check("multi_not_held", held_valid, 0);
    cyc(1); check("multi_single_pulse", multi_press, 0);
    btn_tl = 1'b0;
    btn_br = 1'b0;
    cyc(8);
    btn_tl = 1'b1;
    cyc(7); check("tl_press_valid", press_valid, 1);
    check("tl_press_color", press_color, 2'b00);

    // Overrun while TL is pending, then a load coinciding with ready
    btn_tl = 1'b0;
    cyc(8);
    btn_br = 1'b1;
    cyc(7); check("overrun_pulse", overrun, 1);
    check("overrun_keeps_valid", press_valid, 1);
    check("overrun_keeps_color", press_color, 2'b00);
    cyc(1); check("overrun_single_pulse", overrun, 0);
    btn_br = 1'b0;
    cyc(8);
    btn_bl = 1'b1;
    cyc(6); press_ready = 1'b1;
    cyc(1); press_ready = 1'b0;
    check("load_wins_valid", press_valid, 1);
    check("load_wins_color", press_color, 2'b10);
    check("load_wins_no_overrun", overrun, 0);
    btn_bl = 1'b0;
    press_ready = 1'b1; cyc(1); press_ready = 1'b0;
    cyc(8);

    // enable=0 press, then reset while held
    enable = 1'b0;
    btn_tr = 1'b1;
    cyc(7); check("dis_held_valid", held_valid, 1);
    check("dis_held_color", held_color, 2'b01);
    check("dis_no_press", press_valid, 0);
    reset = 1'b1;
    cyc(2); check("midrst_held_valid", held_valid, 0);
    check("midrst_held_color", held_color, 0);
    check("midrst_press_valid", press_valid, 0);
    reset  = 1'b0;
    enable = 1'b1;
    cyc(6); check("postrst_before_latency", press_valid, 0);
    cyc(1); check("postrst_press_valid", press_valid, 1);
    check("postrst_press_color", press_color, 2'b01);
    btn_tr = 1'b0;
    press_ready = 1'b1; cyc(1); press_ready = 1'b0;
    cyc(10);

    // Inactivity timer (pulses only when the feature is built)
    enable = 1'b0;
    cyc(2);
    enable = 1'b1;
    cyc(19); check("to_before_first", timeout, 0);
    cyc(1);  check("to_first", timeout, TO_EN);
    cyc(1);  check("to_one_cycle", timeout, 0);
    cyc(19); check("to_second", timeout, TO_EN);
    cyc(8);
    btn_bl      = 1'b1;
    press_ready = 1'b1;
    cyc(12); check("to_restarted", timeout, 0);
    btn_bl = 1'b0;
    cyc(45);
    press_ready = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
